// File: rtl/column_pkg.sv
// Shared constants and types for the column write sequencer and its clients.
package column_pkg;

    localparam int unsigned NUM_COLS = 640;
    localparam int unsigned COL_W    = 28;
    localparam int unsigned CA_W     = 10;
    localparam int unsigned BUS_W    = 16;

    // Avalon register map
    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    // CTRL register bit positions
    localparam int unsigned CTRL_RESTART_BIT = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    typedef enum logic [1:0] {
        S_LO   = 2'd0,
        S_HI   = 2'd1,
        S_FULL = 2'd2
    } colseq_state_t;

endpackage

// File: rtl/column_write_sequencer.sv
// Column write sequencer: packs two 16-bit Avalon DATA words into one column
// entry, writes it into the back half of the double-buffered column RAM, and
// flips the front/back buffers at the first vertical blank after a full frame.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   chipselect/write/read   Avalon slave strobes
//   address, writedata      Avalon register select (DATA/CTRL/STATUS) and data
//   readdata                STATUS read data, combinational, 0 when not reading
//   vblank_start            one-cycle pulse at the start of vertical blank
//   col_we/col_waddr/col_wdata  column RAM write port, {buffer, column} address
//   front_sel               buffer currently shown by the renderer
//   swap_pulse              one-cycle pulse the cycle after a buffer swap
module column_write_sequencer
    import column_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [1:0]          address,
    input  logic [BUS_W-1:0]    writedata,
    output logic [BUS_W-1:0]    readdata,
    input  logic                vblank_start,
    output logic                col_we,
    output logic [CA_W:0]       col_waddr,
    output logic [COL_W-1:0]    col_wdata,
    output logic                front_sel,
    output logic                swap_pulse
);

    localparam int unsigned HI_W = COL_W - BUS_W;

    colseq_state_t       state;
    logic [CA_W-1:0]     col_ptr;
    logic [BUS_W-1:0]    hold;
    logic                pending;
    logic                overflow;

    logic                data_wr;
    logic                ctrl_wr;
    logic                restart;
    logic                clr_ovf;
    logic                do_swap;
    logic                last_col;
    logic [BUS_W-1:0]    status;

    // Bus decode; restart takes priority over any swap in the same cycle
    assign data_wr  = chipselect & write & (address == ADDR_DATA);
    assign ctrl_wr  = chipselect & write & (address == ADDR_CTRL);
    assign restart  = ctrl_wr & writedata[CTRL_RESTART_BIT];
    assign clr_ovf  = ctrl_wr & writedata[CTRL_CLR_OVF_BIT];
    assign do_swap  = vblank_start & pending & ~restart;
    assign last_col = (col_ptr == CA_W'(NUM_COLS - 1));

    // STATUS register image
    assign status   = BUS_W'({overflow, pending, front_sel, 2'(state), 1'b0, col_ptr});
    assign readdata = (chipselect & read & (address == ADDR_STATUS)) ? status : '0;

    // Upload FSM with registered RAM write port and swap control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_LO;
            col_ptr    <= '0;
            hold       <= '0;
            pending    <= 1'b0;
            overflow   <= 1'b0;
            front_sel  <= 1'b0;
            swap_pulse <= 1'b0;
            col_we     <= 1'b0;
            col_waddr  <= '0;
            col_wdata  <= '0;
        end else begin
            col_we     <= 1'b0;
            swap_pulse <= do_swap;

            // Clear first so an overflow-setting write in the same cycle wins
            if (clr_ovf) begin
                overflow <= 1'b0;
            end

            if (restart) begin
                state   <= S_LO;
                col_ptr <= '0;
                pending <= 1'b0;
                hold    <= '0;
            end else begin
                // pending implies S_FULL, so a swap never collides with S_LO/S_HI data
                if (do_swap) begin
                    front_sel <= ~front_sel;
                    pending   <= 1'b0;
                    state     <= S_LO;
                end

                if (data_wr) begin
                    unique case (state)
                        S_LO: begin
                            hold  <= writedata;
                            state <= S_HI;
                        end
                        S_HI: begin
                            // Buffer bit frozen here so a swap cannot redirect this write
                            col_we    <= 1'b1;
                            col_waddr <= {~front_sel, col_ptr};
                            col_wdata <= {writedata[HI_W-1:0], hold};
                            if (last_col) begin
                                col_ptr <= '0;
                                pending <= 1'b1;
                                state   <= S_FULL;
                            end else begin
                                col_ptr <= col_ptr + CA_W'(1);
                                state   <= S_LO;
                            end
                        end
                        S_FULL: begin
                            overflow <= 1'b1;
                        end
                        default: begin
                            state <= S_LO;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_column_write_sequencer.sv
// Directed testbench for column_write_sequencer.
module tb_column_write_sequencer;
    import column_pkg::*;

    localparam int unsigned HI_W = COL_W - 16;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                chipselect;
    logic                write;
    logic                read;
    logic [1:0]          address;
    logic [15:0]         writedata;
    logic [15:0]         readdata;
    logic                vblank_start;
    logic                col_we;
    logic [CA_W:0]       col_waddr;
    logic [COL_W-1:0]    col_wdata;
    logic                front_sel;
    logic                swap_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [CA_W:0]    cap_addr[$];
    logic [COL_W-1:0] cap_data[$];
    int               swap_count = 0;

    always #10 clk = ~clk;

    column_write_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .chipselect   (chipselect),
        .write        (write),
        .read         (read),
        .address      (address),
        .writedata    (writedata),
        .readdata     (readdata),
        .vblank_start (vblank_start),
        .col_we       (col_we),
        .col_waddr    (col_waddr),
        .col_wdata    (col_wdata),
        .front_sel    (front_sel),
        .swap_pulse   (swap_pulse)
    );

    // Passive capture of RAM writes and swap pulses, sampled mid-cycle
    always @(negedge clk) begin
        if (col_we === 1'b1) begin
            cap_addr.push_back(col_waddr);
            cap_data.push_back(col_wdata);
        end
        if (swap_pulse === 1'b1) swap_count++;
    end

    task automatic bus_write(input logic [1:0] a, input logic [15:0] d, input logic vb);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d; vblank_start = vb;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0; address = 2'd0; writedata = 16'h0; vblank_start = 1'b0;
    endtask

    task automatic read_status(output logic [15:0] v);
        @(negedge clk);
        chipselect = 1'b1; read = 1'b1; address = ADDR_STATUS;
        #1 v = readdata;
        chipselect = 1'b0; read = 1'b0; address = 2'd0;
    endtask

    task automatic settle();
        @(negedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [15:0] st;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        tests_run++;
        if ({col_we, swap_pulse, front_sel} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags: got we/swap/front=%b expected 000", {col_we, swap_pulse, front_sel});
        end
        tests_run++;
        if ({col_waddr, col_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_bus: got addr=%h data=%h expected 0", col_waddr, col_wdata);
        end
        tests_run++;
        if (readdata !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_readdata: got %h expected 0000", readdata);
        end
        @(negedge clk);
        reset_n = 1'b1;
        read_status(st);
        tests_run++;
        if (st !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 0000", st);
        end
    endtask

    task automatic test_full_frame();
        logic [15:0]      st;
        logic [CA_W:0]    ea;
        logic [COL_W-1:0] ed;
        int               bad;
        cap_addr.delete(); cap_data.delete();
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            bus_write(ADDR_DATA, 16'(i), 1'b0);
            bus_write(ADDR_DATA, 16'(i ^ 'hFFF), 1'b0);
        end
        settle();
        tests_run++;
        if (cap_addr.size() != int'(NUM_COLS)) begin
            tests_failed++;
            $display("FAIL frame_count: got %0d writes expected %0d", cap_addr.size(), NUM_COLS);
        end
        bad = -1;
        for (int i = 0; i < cap_addr.size() && i < int'(NUM_COLS); i++) begin
            ea = {1'b1, CA_W'(i)};
            ed = {HI_W'(i ^ 'hFFF), 16'(i)};
            if (bad < 0 && (cap_addr[i] !== ea || cap_data[i] !== ed)) bad = i;
        end
        tests_run++;
        if (bad >= 0) begin
            tests_failed++;
            $display("FAIL frame_entries: col %0d got addr=%h data=%h expected addr=%h data=%h",
                     bad, cap_addr[bad], cap_data[bad], {1'b1, CA_W'(bad)}, {HI_W'(bad ^ 'hFFF), 16'(bad)});
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h5000) begin
            tests_failed++;
            $display("FAIL frame_status: got %h expected 5000", st);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] st;
        cap_addr.delete(); cap_data.delete();
        for (int i = 0; i < 5; i++) bus_write(ADDR_DATA, 16'hAAAA, 1'b0);
        settle();
        tests_run++;
        if (cap_addr.size() != 0) begin
            tests_failed++;
            $display("FAIL overflow_drop: got %0d writes expected 0", cap_addr.size());
        end
        read_status(st);
        tests_run++;
        if (st !== 16'hD000) begin
            tests_failed++;
            $display("FAIL overflow_set: got %h expected d000", st);
        end
        bus_write(ADDR_CTRL, 16'h0002, 1'b0);
        read_status(st);
        tests_run++;
        if (st !== 16'h5000) begin
            tests_failed++;
            $display("FAIL overflow_clear: got %h expected 5000", st);
        end
    endtask

    task automatic test_swap();
        logic [15:0] st;
        swap_count = 0;
        @(negedge clk); vblank_start = 1'b1;
        @(negedge clk); vblank_start = 1'b0;
        #1;
        tests_run++;
        if ({swap_pulse, front_sel} !== 2'b11) begin
            tests_failed++;
            $display("FAIL swap_edge: got pulse/front=%b expected 11", {swap_pulse, front_sel});
        end
        @(negedge clk); #1;
        tests_run++;
        if (swap_pulse !== 1'b0 || swap_count != 1) begin
            tests_failed++;
            $display("FAIL swap_width: got pulse=%b count=%0d expected 0 and 1", swap_pulse, swap_count);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h2000) begin
            tests_failed++;
            $display("FAIL swap_status: got %h expected 2000", st);
        end
        cap_addr.delete(); cap_data.delete();
        bus_write(ADDR_DATA, 16'h1234, 1'b0);
        bus_write(ADDR_DATA, 16'h0ABC, 1'b0);
        settle();
        tests_run++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 11'h000 || cap_data[0] !== 28'hABC1234) begin
            tests_failed++;
            $display("FAIL swap_next_frame: got n=%0d addr=%h data=%h expected 1 000 abc1234",
                     cap_addr.size(), cap_addr.size() ? cap_addr[0] : '0, cap_data.size() ? cap_data[0] : '0);
        end
    endtask

    task automatic test_restart();
        logic [15:0] st;
        cap_addr.delete(); cap_data.delete();
        bus_write(ADDR_DATA, 16'h1111, 1'b0);
        bus_write(ADDR_DATA, 16'h0222, 1'b0);
        bus_write(ADDR_DATA, 16'h3333, 1'b0);
        settle();
        tests_run++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 11'h001 || cap_data[0] !== 28'h2221111) begin
            tests_failed++;
            $display("FAIL restart_pre_col: got n=%0d addr=%h data=%h expected 1 001 2221111",
                     cap_addr.size(), cap_addr.size() ? cap_addr[0] : '0, cap_data.size() ? cap_data[0] : '0);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h2802) begin
            tests_failed++;
            $display("FAIL restart_pre_status: got %h expected 2802", st);
        end
        bus_write(ADDR_CTRL, 16'h0001, 1'b0);
        read_status(st);
        tests_run++;
        if (st !== 16'h2000) begin
            tests_failed++;
            $display("FAIL restart_status: got %h expected 2000", st);
        end
        cap_addr.delete(); cap_data.delete();
        bus_write(ADDR_DATA, 16'h4444, 1'b0);
        bus_write(ADDR_DATA, 16'h0555, 1'b0);
        settle();
        tests_run++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 11'h000 || cap_data[0] !== 28'h5554444) begin
            tests_failed++;
            $display("FAIL restart_col0: got n=%0d addr=%h data=%h expected 1 000 5554444",
                     cap_addr.size(), cap_addr.size() ? cap_addr[0] : '0, cap_data.size() ? cap_data[0] : '0);
        end
    endtask

    task automatic test_coincident_vblank();
        logic [15:0] st;
        bus_write(ADDR_CTRL, 16'h0001, 1'b0);
        cap_addr.delete(); cap_data.delete();
        swap_count = 0;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            bus_write(ADDR_DATA, 16'(i * 3), 1'b0);
            bus_write(ADDR_DATA, 16'(i), (i == int'(NUM_COLS) - 1) ? 1'b1 : 1'b0);
        end
        settle();
        tests_run++;
        if (swap_count != 0 || front_sel !== 1'b1) begin
            tests_failed++;
            $display("FAIL coincident_no_swap: got swaps=%0d front=%b expected 0 1", swap_count, front_sel);
        end
        tests_run++;
        if (cap_addr.size() != int'(NUM_COLS) || cap_addr[$] !== 11'h27F || cap_data[$] !== 28'h27F077D) begin
            tests_failed++;
            $display("FAIL coincident_last_col: got n=%0d addr=%h data=%h expected 640 27f 27f077d",
                     cap_addr.size(), cap_addr.size() ? cap_addr[$] : '0, cap_data.size() ? cap_data[$] : '0);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h7000) begin
            tests_failed++;
            $display("FAIL coincident_status: got %h expected 7000", st);
        end
        @(negedge clk); vblank_start = 1'b1;
        @(negedge clk); vblank_start = 1'b0;
        settle();
        tests_run++;
        if (swap_count != 1 || front_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL coincident_late_swap: got swaps=%0d front=%b expected 1 0", swap_count, front_sel);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h0000) begin
            tests_failed++;
            $display("FAIL coincident_post_status: got %h expected 0000", st);
        end
    endtask

    task automatic test_restart_vs_vblank();
        logic [15:0] st;
        for (int i = 0; i < int'(NUM_COLS); i++) begin
            bus_write(ADDR_DATA, 16'(i), 1'b0);
            bus_write(ADDR_DATA, 16'h0001, 1'b0);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h5000) begin
            tests_failed++;
            $display("FAIL rvv_pending: got %h expected 5000", st);
        end
        swap_count = 0;
        bus_write(ADDR_CTRL, 16'h0001, 1'b1);
        settle();
        tests_run++;
        if (swap_count != 0 || front_sel !== 1'b0) begin
            tests_failed++;
            $display("FAIL rvv_no_swap: got swaps=%0d front=%b expected 0 0", swap_count, front_sel);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h0000) begin
            tests_failed++;
            $display("FAIL rvv_status: got %h expected 0000", st);
        end
    endtask

    task automatic test_reset_mid_upload();
        logic [15:0] st;
        bus_write(ADDR_DATA, 16'h0BEE, 1'b0);
        @(negedge clk);
        chipselect = 1'b1; write = 1'b1; address = ADDR_DATA; writedata = 16'h0777;
        @(posedge clk);
        #2;
        tests_run++;
        if (col_we !== 1'b1 || col_waddr !== 11'h400 || col_wdata !== 28'h7770BEE) begin
            tests_failed++;
            $display("FAIL midreset_pre_we: got we=%b addr=%h data=%h expected 1 400 7770bee", col_we, col_waddr, col_wdata);
        end
        reset_n = 1'b0;
        #1;
        tests_run++;
        if ({col_we, swap_pulse, front_sel, col_waddr, col_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL midreset_async: got we=%b addr=%h data=%h expected all 0", col_we, col_waddr, col_wdata);
        end
        chipselect = 1'b0; write = 1'b0; writedata = 16'h0;
        @(negedge clk);
        reset_n = 1'b1;
        cap_addr.delete(); cap_data.delete();
        bus_write(ADDR_DATA, 16'h0001, 1'b0);
        bus_write(ADDR_DATA, 16'h0002, 1'b0);
        settle();
        tests_run++;
        if (cap_addr.size() != 1 || cap_addr[0] !== 11'h400 || cap_data[0] !== 28'h0020001) begin
            tests_failed++;
            $display("FAIL midreset_restart: got n=%0d addr=%h data=%h expected 1 400 0020001",
                     cap_addr.size(), cap_addr.size() ? cap_addr[0] : '0, cap_data.size() ? cap_data[0] : '0);
        end
        read_status(st);
        tests_run++;
        if (st !== 16'h0001) begin
            tests_failed++;
            $display("FAIL midreset_status: got %h expected 0001", st);
        end
    endtask

    initial begin
        reset_n      = 1'b0;
        chipselect   = 1'b0;
        write        = 1'b0;
        read         = 1'b0;
        address      = 2'd0;
        writedata    = 16'h0;
        vblank_start = 1'b0;
        test_reset();
        test_full_frame();
        test_overflow();
        test_swap();
        test_restart();
        test_coincident_vblank();
        test_restart_vs_vblank();
        test_reset_mid_upload();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
